shift_chain_sequencer: RTL and testbench
========================================

Name: shift_chain_sequencer

Overview:
- Controller that sequences an external free-running serial shift-register chain (ports clk/reset/d/dout, shifts every clock, no enable).
- Accepts parallel words over a valid/ready handshake and drives them serially, LSB first, into the chain's d.
- Recaptures the bits from the chain's dout after the chain latency and returns the word on a valid/ready output.
- Sits between a parallel producer/consumer and the serial datapath; one word in flight at a time.

Parameters:
- WIDTH, 8, word width in bits (>=1).
- LATENCY, 4, clock cycles from a bit being driven on sr_d to that bit being valid on sr_dout (equals chain stage count, >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to send through the chain.
- sr_d  output  1  serial bit to chain input d.
- sr_dout  input  1  serial bit from chain output dout.
- out_valid  output  1  captured word available on out_data.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  word recaptured from the chain.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, tx/rx registers=0; in_ready=0 while asserted, then 1 in IDLE; sr_d=0; out_valid=0; out_data=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, sr_d=0.
  - On in_valid&in_ready: latch in_data into tx register, clear rx register, cnt=0, go to SHIFT.
- SHIFT:
  - in_ready=0. Runs exactly WIDTH+LATENCY cycles, cnt = 0 .. WIDTH+LATENCY-1.
  - sr_d = tx[cnt] for cnt<WIDTH, else 0. sr_d is driven from registers only, glitch-free.
  - At the end of each cycle with cnt>=LATENCY: rx[cnt-LATENCY] <= sr_dout.
  - After cnt=WIDTH+LATENCY-1: out_data <= completed rx, out_valid <= 1, go to DONE.
  - Counter width is $clog2(WIDTH+LATENCY+1). No wrap occurs within a word.
- DONE:
  - out_valid=1, out_data held stable, sr_d=0, in_ready=0.
  - On out_ready=1: out_valid <= 0, go to IDLE.
  - Next word is accepted no earlier than the cycle after the DONE handshake. Per-word throughput is WIDTH+LATENCY+2 cycles minimum.
- Boundary conditions:
  - in_valid while not in IDLE: ignored; producer must hold it.
  - out_ready while out_valid=0: ignored.
  - out_ready already high on DONE entry: handshake completes in the first DONE cycle.
  - Reset mid-SHIFT or mid-DONE: word dropped, all outputs return to reset values immediately. The chain is not flushed by the controller.
  - Trailing zeros driven during SHIFT flush the chain, so the next word never sees stale bits.
- in_data may change freely after acceptance.

Optional Feature:
- Macro: SHIFT_CHAIN_SEQUENCER_CHECK_EN.
- Defined:
  - Adds output port `mismatch` (1 bit, reset 0).
  - On DONE entry, mismatch <= (rx != tx).
  - mismatch is held through DONE and cleared on the DONE handshake. It flags a corrupt chain, for example a blocking-assignment collapsed shift register.
- Undefined: port absent, no compare logic, all other behaviour identical.

Test Plan (WIDTH=8, LATENCY=4, bench model = 4-stage nonblocking shift chain):
- Reset released, in_data=0xA5 with in_valid pulse -> in_ready low for 12 SHIFT cycles; sr_d sequence 1,0,1,0,0,1,0,1,0,0,0,0; out_valid rises 13 cycles after acceptance; out_data=0xA5.
- Back-to-back 0x00, 0xFF, 0x3C with out_ready tied high -> outputs 0x00, 0xFF, 0x3C in order, 14-cycle spacing, no stale bits.
- out_ready held low for 20 cycles in DONE with out_data=0x96 -> out_valid stays 1, out_data stays 0x96, in_ready stays 0, new in_valid ignored until handshake.
- reset asserted at SHIFT cnt=5 -> out_valid=0, sr_d=0, in_ready=1 immediately after release; next word 0x5A returns 0x5A.
- CHECK_EN defined, bench chain replaced by a 1-stage (collapsed) chain, in_data=0xA5 -> mismatch=1 with out_valid; with the correct chain, mismatch=0.
- WIDTH=1, LATENCY=1 build, in_data=1 -> SHIFT lasts 2 cycles, out_data=1.

Source files
------------

// File: rtl/shift_chain_sequencer.sv
// ---------------------------------------------------------------------------
// shift_chain_sequencer
//
// Purpose:
//   Feeds parallel words, one at a time, into an external free-running serial
//   shift-register chain. Each word is driven LSB first on sr_d. The bits are
//   recaptured from sr_dout LATENCY cycles later, and the rebuilt word is
//   returned on a valid/ready output. Only one word is in flight at a time.
//
// Parameters:
//   WIDTH    word width in bits (>= 1)
//   LATENCY  cycles from a bit on sr_d to that bit on sr_dout (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low (0 = in reset)
//   in_valid   producer has a word on in_data
//   in_ready   controller can accept a word (only in IDLE)
//   in_data    word to send through the chain
//   sr_d       serial bit to the chain input (driven from a flop)
//   sr_dout    serial bit from the chain output
//   out_valid  recaptured word available on out_data
//   out_ready  consumer accepts the word
//   out_data   word recaptured from the chain
//   mismatch   (only with SHIFT_CHAIN_SEQUENCER_CHECK_EN) recaptured word
//              differs from the word that was sent
//
// Optional feature:
//   Define SHIFT_CHAIN_SEQUENCER_CHECK_EN to add the mismatch port and the
//   sent-versus-received compare. Without it the port and logic are absent.
// ---------------------------------------------------------------------------
module shift_chain_sequencer #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sr_d,
    input  logic             sr_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
    ,
    output logic             mismatch
`endif
);

    // Counter must hold values up to WIDTH+LATENCY-1 without wrapping.
    localparam int CW = $clog2(WIDTH + LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH + LATENCY - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] rx_next;
    logic             next_bit;

    // NOTE: in_ready is gated by reset so it reads 0 for the whole time reset
    // is asserted, even though the state register already sits at IDLE.
    assign in_ready = reset && (state == IDLE);

    // rx_next merges the bit arriving this cycle. On the last SHIFT cycle
    // this makes the final bit part of the word handed to out_data.
    always_comb begin
        rx_next = rx;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(i + LATENCY)) rx_next[i] = sr_dout;
        end
    end

    // sr_d is a flop, so its next value is the bit for cnt+1. Past the end
    // of the word it is zero, which also flushes the chain.
    always_comb begin
        next_bit = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            if (cnt == CW'(i - 1)) next_bit = tx[i];
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; a blocking chain here would collapse stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            tx        <= '0;
            rx        <= '0;
            sr_d      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
            mismatch  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tx    <= in_data;
                        rx    <= '0;
                        cnt   <= '0;
                        sr_d  <= in_data[0];
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    rx   <= rx_next;
                    sr_d <= next_bit;
                    if (cnt == LAST) begin
                        out_data  <= rx_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
                        mismatch  <= (rx_next != tx);
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
                        mismatch  <= 1'b0;
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_chain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_chain_sequencer
//
// Drives a WIDTH=8/LATENCY=4 sequencer wired to a 4-stage non-blocking shift
// chain model, plus a WIDTH=1/LATENCY=1 instance on a 1-stage chain.
// Directed vectors come from a table; the multi-cycle corners (back-to-back
// spacing, output backpressure, reset mid-shift, collapsed chain) are written
// out as explicit sequences. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_shift_chain_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT: WIDTH=8, LATENCY=4 ----------------
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       sr_d;
    logic       sr_dout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
    logic       mismatch;
    logic       mismatch1;
`endif

    // External chain model; collapse=1 taps after the first stage to mimic a
    // shift register whose stages collapsed into one.
    logic [3:0] chain = '0;
    bit         collapse = 1'b0;
    always @(posedge clk) chain <= {chain[2:0], sr_d};
    assign sr_dout = collapse ? chain[0] : chain[3];

    shift_chain_sequencer #(.WIDTH(8), .LATENCY(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sr_d      (sr_d),
        .sr_dout   (sr_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
        ,
        .mismatch  (mismatch)
`endif
    );

    // ---------------- small DUT: WIDTH=1, LATENCY=1 ----------------
    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] in_data1;
    logic       sr_d1;
    logic       sr_dout1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] out_data1;
    logic       chain1 = 1'b0;
    always @(posedge clk) chain1 <= sr_d1;
    assign sr_dout1 = chain1;

    shift_chain_sequencer #(.WIDTH(1), .LATENCY(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .sr_d      (sr_d1),
        .sr_dout   (sr_dout1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1)
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
        ,
        .mismatch  (mismatch1)
`endif
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  exp_out;
        logic [11:0] exp_sr;   // sr_d over the 12 SHIFT cycles, bit k = cnt k
    } vec_t;

    vec_t vecs[5];
    logic mm_seen;

    // Waits for out_valid (bounded), returns out_data, then completes the
    // output handshake. Called at a falling edge, returns at a falling edge.
    task automatic finish_word(output logic [7:0] d);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", {31'd0, out_valid}, 32'd1);
        d = out_data;
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
        mm_seen = mismatch;
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Sends one word and records the sr_d pattern, the cycle count from the
    // acceptance edge to out_valid, and any cycle where in_ready was high
    // while the word was shifting.
    task automatic run_word(input logic [7:0] w, output logic [7:0] got,
                            output logic [11:0] sr_seq, output int lat,
                            output int ir_bad);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~w;   // producer may change data after acceptance
        lat    = 1;
        sr_seq = '0;
        ir_bad = 0;
        while (!out_valid && lat < 40) begin
            if (lat <= 12) sr_seq[lat-1] = sr_d;
            if (in_ready) ir_bad++;
            @(negedge clk);
            lat++;
        end
        finish_word(got);
    endtask

    logic [7:0]  got;
    logic [11:0] sr_seq;
    int          lat;
    int          ir_bad;

    logic [7:0]  bb_words[3];
    logic [7:0]  bb_out[3];
    int          bb_cyc[3];
    int          nout;
    int          idx;
    int          shift1;

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;
        mm_seen    = 1'b0;

        vecs[0] = '{data: 8'hA5, exp_out: 8'hA5, exp_sr: 12'b0000_1010_0101};
        vecs[1] = '{data: 8'h01, exp_out: 8'h01, exp_sr: 12'b0000_0000_0001};
        vecs[2] = '{data: 8'h80, exp_out: 8'h80, exp_sr: 12'b0000_1000_0000};
        vecs[3] = '{data: 8'hC3, exp_out: 8'hC3, exp_sr: 12'b0000_1100_0011};
        vecs[4] = '{data: 8'h6E, exp_out: 8'h6E, exp_sr: 12'b0000_0110_1110};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_sr_d",      {31'd0, sr_d},      32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_in_ready1", {31'd0, in_ready1}, 32'd0);
        reset = 1'b1;
        #1;
        check("rel_in_ready",  {31'd0, in_ready},  32'd1);
        check("rel_in_ready1", {31'd0, in_ready1}, 32'd1);
        @(negedge clk);

        // ---- table-driven words ----
        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i].data, got, sr_seq, lat, ir_bad);
            check($sformatf("vec%0d_out_data", i), {24'd0, got},    {24'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_sr_d_seq", i), {20'd0, sr_seq}, {20'd0, vecs[i].exp_sr});
            check($sformatf("vec%0d_latency", i),  lat,             32'd13);
            check($sformatf("vec%0d_in_ready", i), ir_bad,          32'd0);
`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
            check($sformatf("vec%0d_mismatch", i), {31'd0, mm_seen}, 32'd0);
`endif
        end

        // ---- back-to-back with out_ready tied high ----
        bb_words[0] = 8'h00;
        bb_words[1] = 8'hFF;
        bb_words[2] = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            bb_out[k] = 8'h55;
            bb_cyc[k] = 0;
        end
        nout = 0;
        idx  = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && nout < 3; k++) begin
            @(negedge clk);
            if (out_valid) begin
                bb_out[nout] = out_data;
                bb_cyc[nout] = cyc;
                nout++;
            end
            if (in_ready && idx < 3) begin
                in_valid = 1'b1;
                in_data  = bb_words[idx];
                idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);   // let the last DONE handshake complete
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bb_count", nout, 32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("bb_word%0d", k), {24'd0, bb_out[k]}, {24'd0, bb_words[k]});
        check("bb_spacing01", bb_cyc[1] - bb_cyc[0], 32'd14);
        check("bb_spacing12", bb_cyc[2] - bb_cyc[1], 32'd14);

        // ---- backpressure: DONE held for 20 cycles, new in_valid ignored ----
        in_valid = 1'b1;
        in_data  = 8'h96;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h11;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data",  {24'd0, out_data},  32'h96);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_after_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_after_hs_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        check("bp_next_accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        finish_word(got);
        check("bp_next_word", {24'd0, got}, 32'h11);

        // ---- reset asserted at SHIFT cnt=5 ----
        in_valid = 1'b1;
        in_data  = 8'hE7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_sr_d_cnt5", {31'd0, sr_d}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sr_d",      {31'd0, sr_d},      32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rel_sr_d",      {31'd0, sr_d},      32'd0);
        check("mid_rel_out_valid", {31'd0, out_valid}, 32'd0);
        run_word(8'h5A, got, sr_seq, lat, ir_bad);
        check("mid_next_word", {24'd0, got}, 32'h5A);

`ifdef SHIFT_CHAIN_SEQUENCER_CHECK_EN
        // ---- collapsed chain must raise mismatch ----
        collapse = 1'b1;
        repeat (4) @(negedge clk);
        run_word(8'hA5, got, sr_seq, lat, ir_bad);
        check("col_out_data", {24'd0, got},      32'h14);
        check("col_mismatch", {31'd0, mm_seen},  32'd1);
        check("col_mm_clear", {31'd0, mismatch}, 32'd0);
        collapse = 1'b0;
        repeat (4) @(negedge clk);
        run_word(8'hA5, got, sr_seq, lat, ir_bad);
        check("good_out_data", {24'd0, got},     32'hA5);
        check("good_mismatch", {31'd0, mm_seen}, 32'd0);
`endif

        // ---- WIDTH=1, LATENCY=1 instance ----
        check("w1_in_ready", {31'd0, in_ready1}, 32'd1);
        in_valid1 = 1'b1;
        in_data1  = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        in_data1  = 1'b0;
        shift1 = 0;
        while (!out_valid1 && shift1 < 20) begin
            shift1++;
            @(negedge clk);
        end
        check("w1_shift_cycles", shift1, 32'd2);
        check("w1_out_valid", {31'd0, out_valid1}, 32'd1);
        check("w1_out_data",  {31'd0, out_data1},  32'd1);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("w1_after_hs", {31'd0, out_valid1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
